multdiv_unit: RTL and testbench

//   Multicycle signed multiply/divide unit in the execute stage, beside the single-cycle ALU.

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/multdiv_unit_abs.sv | 15 +
 rtl/multdiv_unit.sv | 143 ++++++++++++++
 tb/tb_multdiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types for the multicycle multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Opcode encoding shared with the execute-stage decoder
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MULT = 2'd1,
    OP_DIV  = 2'd2
  } op_t;

  // Iteration counter width for a given operand width (COUNT_W = clog2(WIDTH)+1)
  function automatic int unsigned count_w(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/multdiv_unit_abs.sv
// Magnitude/sign extraction with an optional forced negation, used both for
// operand magnitudes and for re-applying the result sign.
module abs_value #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  assign sign = value[WIDTH-1];
  assign mag  = (sign ^ negate) ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) unit with a
// final sign-fix cycle; one result pulse per completed operation.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             resultRDY
);

  localparam int unsigned COUNT_W = count_w(WIDTH);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WIDTH - 1);

  state_t               state, state_nx;
  op_t                  op;
  logic [COUNT_W-1:0]   count;
  logic [WIDTH-1:0]     hi, lo, mag_b;
  logic                 sign_a, sign_b, b_zero;
  logic                 start;

  logic [WIDTH-1:0]     mag_a_in, mag_b_in;
  logic                 sign_a_in, sign_b_in;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_borrow;

  logic [2*WIDTH-1:0]   fix_in, fix_val;
  logic                 fix_sign_unused;
  logic                 fix_ovf;

  assign start = ctrl_MULT | ctrl_DIV;

  abs_value #(.WIDTH(WIDTH)) u_abs_a (
    .value(operandA), .negate(1'b0), .mag(mag_a_in), .sign(sign_a_in)
  );

  abs_value #(.WIDTH(WIDTH)) u_abs_b (
    .value(operandB), .negate(1'b0), .mag(mag_b_in), .sign(sign_b_in)
  );

  // Magnitudes are zero-extended to 2*WIDTH so the MSB is never set and the
  // instance acts as a pure conditional negate on the final value.
  assign fix_in = (op == OP_MULT) ? {hi, lo} : {{WIDTH{1'b0}}, lo};

  abs_value #(.WIDTH(2 * WIDTH)) u_abs_fix (
    .value(fix_in), .negate(sign_a ^ sign_b), .mag(fix_val), .sign(fix_sign_unused)
  );

  always_comb begin
    mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    div_shift  = {hi, lo[WIDTH-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, mag_b};
    div_borrow = div_diff[WIDTH+1];
    fix_ovf    = fix_val[2*WIDTH-1:WIDTH] != {WIDTH{fix_val[WIDTH-1]}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ctrl_MULT) begin
      state_nx = MUL;
    end else if (ctrl_DIV) begin
      state_nx = DIV;
    end else begin
      unique case (state)
        IDLE:    state_nx = IDLE;
        MUL:     if (count == LAST) state_nx = FIX;
        DIV:     if (b_zero || count == LAST) state_nx = FIX;
        FIX:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op        <= OP_NONE;
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      mag_b     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      resultRDY <= 1'b0;
    end else begin
      resultRDY <= 1'b0;
      if (start) begin
        op     <= ctrl_MULT ? OP_MULT : OP_DIV;
        hi     <= '0;
        lo     <= mag_a_in;
        mag_b  <= mag_b_in;
        sign_a <= sign_a_in;
        sign_b <= sign_b_in;
        b_zero <= (operandB == '0);
        count  <= '0;
      end else begin
        unique case (state)
          MUL: begin
            hi    <= mul_sum[WIDTH:1];
            lo    <= {mul_sum[0], lo[WIDTH-1:1]};
            count <= count + COUNT_W'(1);
          end
          DIV: begin
            if (!b_zero) begin
              hi    <= div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
              lo    <= {lo[WIDTH-2:0], ~div_borrow};
              count <= count + COUNT_W'(1);
            end
          end
          FIX: begin
            resultRDY <= 1'b1;
            if (op == OP_DIV && b_zero) begin
              result    <= '0;
              exception <= 1'b1;
            end else begin
              result    <= fix_val[WIDTH-1:0];
              exception <= fix_ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and randomized checks of multdiv_unit results, flags and latency.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic [31:0] result;
  logic        exception;
  logic        resultRDY;

  int vectors = 0;
  int miscompares = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .operandA(operandA), .operandB(operandB),
    .result(result), .exception(exception), .resultRDY(resultRDY)
  );

  always #5 clock = ~clock;

  // Drive a one-cycle start pulse; the posedge inside is edge 0.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; operandA = a; operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    operandA = $urandom; operandB = $urandom;
  endtask

  // Edges after edge 0 until resultRDY is seen; -1 if not within limit.
  task automatic wait_rdy(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clock); #1;
      if (resultRDY === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 00000000", result); end
    vectors++;
    if (exception !== 1'b0) begin miscompares++; $display("FAIL reset_exception: got %b expected 0", exception); end
    vectors++;
    if (resultRDY !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b expected 0", resultRDY); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] ta [0:2] = '{32'd7,        32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] tb [0:2] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] tr [0:2] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h0000_0001};
    logic        te [0:2] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(1'b1, 1'b0, ta[i], tb[i]);
      wait_rdy(40, lat);
      vectors++;
      if (lat !== 33) begin miscompares++; $display("FAIL mult%0d_latency: got %0d expected 33", i, lat); end
      vectors++;
      if (result !== tr[i]) begin miscompares++; $display("FAIL mult%0d_result: got %h expected %h", i, result, tr[i]); end
      vectors++;
      if (exception !== te[i]) begin miscompares++; $display("FAIL mult%0d_exception: got %b expected %b", i, exception, te[i]); end
      @(posedge clock); #1;
      vectors++;
      if (resultRDY !== 1'b0) begin miscompares++; $display("FAIL mult%0d_rdy_clear: got %b expected 0", i, resultRDY); end
      vectors++;
      if (result !== tr[i]) begin miscompares++; $display("FAIL mult%0d_hold: got %h expected %h", i, result, tr[i]); end
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [0:3] = '{32'hFFFF_FF9C, 32'd100,       32'd5,  32'h8000_0000};
    logic [31:0] tb [0:3] = '{32'd7,        32'hFFFF_FFF9, 32'd0,  32'hFFFF_FFFF};
    logic [31:0] tr [0:3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd0,  32'h8000_0000};
    logic        te [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          tl [0:3] = '{33, 33, 2, 33};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(1'b0, 1'b1, ta[i], tb[i]);
      wait_rdy(40, lat);
      vectors++;
      if (lat !== tl[i]) begin miscompares++; $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, tl[i]); end
      vectors++;
      if (result !== tr[i]) begin miscompares++; $display("FAIL div%0d_result: got %h expected %h", i, result, tr[i]); end
      vectors++;
      if (exception !== te[i]) begin miscompares++; $display("FAIL div%0d_exception: got %b expected %b", i, exception, te[i]); end
      @(posedge clock); #1;
      vectors++;
      if (resultRDY !== 1'b0) begin miscompares++; $display("FAIL div%0d_rdy_clear: got %b expected 0", i, resultRDY); end
    end
  endtask

  task automatic test_async_reset();
    int lat;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (result !== 32'h0) begin miscompares++; $display("FAIL async_reset_result: got %h expected 00000000", result); end
    vectors++;
    if (exception !== 1'b0) begin miscompares++; $display("FAIL async_reset_exception: got %b expected 0", exception); end
    vectors++;
    if (resultRDY !== 1'b0) begin miscompares++; $display("FAIL async_reset_rdy: got %b expected 0", resultRDY); end
    @(negedge clock);
    reset = 1'b0;
    wait_rdy(40, lat);
    vectors++;
    if (lat !== -1) begin miscompares++; $display("FAIL async_reset_no_rdy: got rdy at %0d expected none", lat); end
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    wait_rdy(40, lat);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 33", lat); end
    vectors++;
    if (result !== 32'd42) begin miscompares++; $display("FAIL post_reset_result: got %h expected 0000002a", result); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    start_op(1'b0, 1'b1, 32'd20, 32'd4);
    wait_rdy(40, lat);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL abort_latency: got %0d expected 33", lat); end
    vectors++;
    if (result !== 32'd5) begin miscompares++; $display("FAIL abort_result: got %h expected 00000005", result); end
    vectors++;
    if (exception !== 1'b0) begin miscompares++; $display("FAIL abort_exception: got %b expected 0", exception); end
    wait_rdy(40, lat);
    vectors++;
    if (lat !== -1) begin miscompares++; $display("FAIL abort_single_rdy: extra rdy at %0d expected none", lat); end
    start_op(1'b1, 1'b1, 32'd2, 32'd3);
    wait_rdy(40, lat);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL both_ctrl_latency: got %0d expected 33", lat); end
    vectors++;
    if (result !== 32'd6) begin miscompares++; $display("FAIL both_ctrl_result: got %h expected 00000006", result); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, er;
    logic        ee, m;
    longint      sa, sb, p, q;
    int          el, lat, kind;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      m    = $urandom_range(0, 1);
      a    = $urandom >> $urandom_range(0, 31);
      b    = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      if (kind == 0) begin m = 1'b0; b = 32'd0; end
      if (kind == 1) begin m = 1'b0; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      el = 33;
      if (m) begin
        p  = sa * sb;
        er = p[31:0];
        ee = (p != longint'($signed(er)));
      end else if (b == 32'd0) begin
        er = 32'd0; ee = 1'b1; el = 2;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        er = 32'h8000_0000; ee = 1'b1;
      end else begin
        q  = sa / sb;
        er = q[31:0];
        ee = 1'b0;
      end
      start_op(m, ~m, a, b);
      wait_rdy(40, lat);
      vectors++;
      if (lat !== el) begin miscompares++; $display("FAIL rand%0d_latency: op=%b a=%h b=%h got %0d expected %0d", n, m, a, b, lat, el); end
      vectors++;
      if (result !== er) begin miscompares++; $display("FAIL rand%0d_result: op=%b a=%h b=%h got %h expected %h", n, m, a, b, result, er); end
      vectors++;
      if (exception !== ee) begin miscompares++; $display("FAIL rand%0d_exception: op=%b a=%h b=%h got %b expected %b", n, m, a, b, exception, ee); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
